// File: rtl/frame_capture_ctrl_if.sv
// Byte-stream, host and frame-buffer RAM port signals of frame_capture_ctrl.
// OVERRUN exists only when FCC_REARM_EN is defined.
interface frame_capture_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              ENABLE;
  logic [7:0]        DBUS;
  logic              HOST_REQ;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic              HOST_ACK;
  logic              HOST_GNT;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_WDATA;
  logic [ADDR_W-1:0] FRAME_BASE;
  logic              FRAME_RDY;
  logic              BUSY;
`ifdef FCC_REARM_EN
  logic              OVERRUN;

  modport master (
    output ENABLE, DBUS, HOST_REQ, HOST_ADDR, HOST_ACK,
    input  HOST_GNT, MEM_WE, MEM_ADDR, MEM_WDATA, FRAME_BASE, FRAME_RDY, BUSY, OVERRUN
  );
  modport slave (
    input  ENABLE, DBUS, HOST_REQ, HOST_ADDR, HOST_ACK,
    output HOST_GNT, MEM_WE, MEM_ADDR, MEM_WDATA, FRAME_BASE, FRAME_RDY, BUSY, OVERRUN
  );
`else
  modport master (
    output ENABLE, DBUS, HOST_REQ, HOST_ADDR, HOST_ACK,
    input  HOST_GNT, MEM_WE, MEM_ADDR, MEM_WDATA, FRAME_BASE, FRAME_RDY, BUSY
  );
  modport slave (
    input  ENABLE, DBUS, HOST_REQ, HOST_ADDR, HOST_ACK,
    output HOST_GNT, MEM_WE, MEM_ADDR, MEM_WDATA, FRAME_BASE, FRAME_RDY, BUSY
  );
`endif
endinterface

// File: rtl/frame_capture_ctrl.sv
// Sync-word hunter and ring-buffer write sequencer sharing one RAM port with a host reader.
// Define FCC_REARM_EN to re-arm hunting right after each frame and add the sticky OVERRUN flag.
module frame_capture_ctrl #(
  parameter int         ADDR_W    = 4,
  parameter int         FRAME_LEN = 4,
  parameter logic [7:0] SYNC0     = 8'hAA,
  parameter logic [7:0] SYNC1     = 8'h55
) (
  input logic                 CLK,
  input logic                 RST,
  frame_capture_ctrl_if.slave bus
);

  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HUNT0   = 3'd1,
    HUNT1   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_s;
  logic [ADDR_W-1:0] start_ptr_r, start_ptr_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              write_s, last_s;

  logic              gnt_r, gnt_s;
  logic              we_r;
  logic              busy_r;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [7:0]        wdata_r, wdata_s;
  logic [ADDR_W-1:0] base_r, base_s;
  logic              rdy_r, rdy_s;
`ifdef FCC_REARM_EN
  logic              ovr_r, ovr_s;
`endif

  // Next-state, pointer bookkeeping and next values of every registered output.
  always_comb begin
    state_s     = state_r;
    wr_ptr_s    = wr_ptr_r;
    start_ptr_s = start_ptr_r;
    cnt_s       = cnt_r;
    write_s     = 1'b0;
    last_s      = 1'b0;
    rdy_s       = rdy_r;
    base_s      = base_r;
    gnt_s       = 1'b0;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
`ifdef FCC_REARM_EN
    ovr_s       = ovr_r;
`endif

    if (!bus.ENABLE) begin
      state_s = IDLE;
      // An interrupted capture leaves no trace: the next frame reuses the same base.
      if (state_r == CAPTURE) begin
        wr_ptr_s = start_ptr_r;
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
    end else begin
      case (state_r)
        IDLE:  state_s = HUNT0;
        HUNT0: begin
          if (bus.DBUS == SYNC0) begin
            state_s = HUNT1;
          end else begin
            state_s = HUNT0;
          end
        end
        HUNT1: begin
          if (bus.DBUS == SYNC1) begin
            state_s     = CAPTURE;
            start_ptr_s = wr_ptr_r;
            cnt_s       = '0;
          end else if (bus.DBUS == SYNC0) begin
            state_s = HUNT1;
          end else begin
            state_s = HUNT0;
          end
        end
        CAPTURE: begin
          write_s  = 1'b1;
          wr_ptr_s = wr_ptr_r + PTR_ONE;
          cnt_s    = cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            last_s = 1'b1;
`ifdef FCC_REARM_EN
            state_s = HUNT0;
`else
            state_s = DONE;
`endif
          end else begin
            state_s = CAPTURE;
          end
        end
        DONE: begin
`ifdef FCC_REARM_EN
          state_s = HUNT0;
`else
          if (bus.HOST_ACK) begin
            state_s = HUNT0;
          end else begin
            state_s = DONE;
          end
`endif
        end
        default: state_s = IDLE;
      endcase
    end

    // Frame completion takes priority over an acknowledge on the same edge.
    if (last_s) begin
      rdy_s  = 1'b1;
      base_s = start_ptr_r;
`ifdef FCC_REARM_EN
      if (rdy_r) begin
        ovr_s = 1'b1;
      end else begin
        ovr_s = ovr_r;
      end
`endif
`ifdef FCC_REARM_EN
    end else if (bus.HOST_ACK) begin
`else
    end else if (bus.HOST_ACK && (state_r == DONE)) begin
`endif
      rdy_s = 1'b0;
    end else begin
      rdy_s = rdy_r;
    end

    // The host never owns the port on an edge that writes or enters CAPTURE.
    gnt_s = bus.HOST_REQ && (state_s != CAPTURE) && !write_s;

    if (write_s) begin
      addr_s  = wr_ptr_r;
      wdata_s = bus.DBUS;
    end else if (gnt_s) begin
      addr_s  = bus.HOST_ADDR;
      wdata_s = wdata_r;
    end else begin
      addr_s  = addr_r;
      wdata_s = wdata_r;
    end
  end

  // State, pointers and registered outputs; RST clears them all asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      wr_ptr_r    <= '0;
      start_ptr_r <= '0;
      cnt_r       <= '0;
      gnt_r       <= 1'b0;
      we_r        <= 1'b0;
      busy_r      <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= 8'h00;
      base_r      <= '0;
      rdy_r       <= 1'b0;
`ifdef FCC_REARM_EN
      ovr_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      wr_ptr_r    <= wr_ptr_s;
      start_ptr_r <= start_ptr_s;
      cnt_r       <= cnt_s;
      gnt_r       <= gnt_s;
      we_r        <= write_s;
      busy_r      <= write_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      base_r      <= base_s;
      rdy_r       <= rdy_s;
`ifdef FCC_REARM_EN
      ovr_r       <= ovr_s;
`endif
    end
  end

  assign bus.HOST_GNT   = gnt_r;
  assign bus.MEM_WE     = we_r;
  assign bus.MEM_ADDR   = addr_r;
  assign bus.MEM_WDATA  = wdata_r;
  assign bus.FRAME_BASE = base_r;
  assign bus.FRAME_RDY  = rdy_r;
  assign bus.BUSY       = busy_r;
`ifdef FCC_REARM_EN
  assign bus.OVERRUN    = ovr_r;
`endif

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl: stimulus queues expected RAM writes and frame
// completions, a monitor pops and compares them as the DUT presents them.
module tb_frame_capture_ctrl;

  logic CLK;
  logic RST;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [3:0] frame_q[$];
  logic       rdy_prev = 1'b0;

  frame_capture_ctrl_if #(.ADDR_W(4)) bus ();

  frame_capture_ctrl #(
    .ADDR_W   (4),
    .FRAME_LEN(4),
    .SYNC0    (8'hAA),
    .SYNC1    (8'h55)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every RAM write and every FRAME_RDY rise must match a queued expectation.
  always @(posedge CLK) begin
    wr_t e;
    logic [3:0] b;
    #1;
    if (!RST) begin
      chk("busy_eq_we", 32'(bus.BUSY), 32'(bus.MEM_WE));
      if (bus.MEM_WE) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.MEM_ADDR, bus.MEM_WDATA);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.MEM_ADDR), 32'(e.addr));
          chk("wr_data", 32'(bus.MEM_WDATA), 32'(e.data));
          chk("wr_cycle", 32'(cyc), 32'(e.cyc));
          chk("gnt_during_write", 32'(bus.HOST_GNT), 32'd0);
        end
      end
      if (bus.FRAME_RDY && !rdy_prev) begin
        if (frame_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame_rdy: got base %0h expected no frame", bus.FRAME_BASE);
        end else begin
          b = frame_q.pop_front();
          chk("frame_base", 32'(bus.FRAME_BASE), 32'(b));
          chk("rdy_with_last_write", 32'(bus.MEM_WE), 32'd1);
        end
      end
    end
    rdy_prev = bus.FRAME_RDY;
  end

  task automatic drive(input logic [7:0] b, input logic pay, input logic [3:0] a, input logic ack);
    wr_t e;
    @(negedge CLK);
    bus.DBUS     = b;
    bus.HOST_ACK = ack;
    if (pay) begin
      e.cyc  = cyc + 1;
      e.addr = a;
      e.data = b;
      exp_q.push_back(e);
    end
  endtask

  task automatic settle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_frame(input logic [3:0] base, input logic [7:0] d0, input logic rise, input logic ack);
    drive(8'hAA, 1'b0, 4'h0, 1'b0);
    drive(8'h55, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(d0 + 8'(i), 1'b1, base + 4'(i), 1'b0);
      if (i == 3 && rise) frame_q.push_back(base);
    end
    drive(8'h00, 1'b0, 4'h0, 1'b0);
    if (ack) begin
      drive(8'h00, 1'b0, 4'h0, 1'b1);
      drive(8'h00, 1'b0, 4'h0, 1'b0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(bus.HOST_GNT), 32'd0);
    chk({tag, "_we"},    32'(bus.MEM_WE), 32'd0);
    chk({tag, "_addr"},  32'(bus.MEM_ADDR), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.MEM_WDATA), 32'd0);
    chk({tag, "_base"},  32'(bus.FRAME_BASE), 32'd0);
    chk({tag, "_rdy"},   32'(bus.FRAME_RDY), 32'd0);
    chk({tag, "_busy"},  32'(bus.BUSY), 32'd0);
`ifdef FCC_REARM_EN
    chk({tag, "_ovr"},   32'(bus.OVERRUN), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    bus.ENABLE = 1'b0; bus.DBUS = 8'h00; bus.HOST_REQ = 1'b0;
    bus.HOST_ADDR = 4'h0; bus.HOST_ACK = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b0;

    // Basic frame at base 0, then AA AA 55 overlap sync at base 4.
    bus.ENABLE = 1'b1;
    drive(8'h00, 1'b0, 4'h0, 1'b0);
    do_frame(4'h0, 8'h11, 1'b1, 1'b1);
    chk("ack_clears_rdy", 32'(bus.FRAME_RDY), 32'd0);
    drive(8'hAA, 1'b0, 4'h0, 1'b0);
    drive(8'hAA, 1'b0, 4'h0, 1'b0);
    drive(8'h55, 1'b0, 4'h0, 1'b0);
    drive(8'h01, 1'b1, 4'h4, 1'b0);
    drive(8'h02, 1'b1, 4'h5, 1'b0);
    drive(8'h03, 1'b1, 4'h6, 1'b0);
    drive(8'h04, 1'b1, 4'h7, 1'b0);
    frame_q.push_back(4'h4);
    drive(8'h00, 1'b0, 4'h0, 1'b1);
    drive(8'h00, 1'b0, 4'h0, 1'b0);

    // Broken syncs: none of these bytes may reach the RAM.
    drive(8'hAA, 1'b0, 4'h0, 1'b0);
    drive(8'h12, 1'b0, 4'h0, 1'b0);
    drive(8'h55, 1'b0, 4'h0, 1'b0);
    for (int i = 1; i <= 4; i++) drive(8'(i), 1'b0, 4'h0, 1'b0);
    drive(8'h55, 1'b0, 4'h0, 1'b0);
    drive(8'hAA, 1'b0, 4'h0, 1'b0);
    drive(8'h00, 1'b0, 4'h0, 1'b0);
    drive(8'h01, 1'b0, 4'h0, 1'b0);
    settle();
    chk("nosync_rdy", 32'(bus.FRAME_RDY), 32'd0);

    // Ring wrap: bases 8, 12, then back to 0.
    do_frame(4'h8, 8'h80, 1'b1, 1'b1);
    do_frame(4'hC, 8'hC0, 1'b1, 1'b1);
    do_frame(4'h0, 8'hE8, 1'b1, 1'b1);

    // Arbitration: host holds the port until sync completes, regains it after the last write.
    @(negedge CLK);
    bus.HOST_REQ = 1'b1; bus.HOST_ADDR = 4'h5; bus.DBUS = 8'h00;
    settle();
    chk("gnt_idle", 32'(bus.HOST_GNT), 32'd1);
    chk("gnt_addr", 32'(bus.MEM_ADDR), 32'd5);
    drive(8'hAA, 1'b0, 4'h0, 1'b0);
    settle();
    chk("gnt_hunt1", 32'(bus.HOST_GNT), 32'd1);
    drive(8'h55, 1'b0, 4'h0, 1'b0);
    settle();
    chk("gnt_drop_on_sync", 32'(bus.HOST_GNT), 32'd0);
    chk("we_low_on_sync", 32'(bus.MEM_WE), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(8'h40 + 8'(i), 1'b1, 4'h4 + 4'(i), 1'b0);
      if (i == 3) frame_q.push_back(4'h4);
      settle();
      chk("gnt_low_capture", 32'(bus.HOST_GNT), 32'd0);
    end
    drive(8'h00, 1'b0, 4'h0, 1'b1);
    settle();
    chk("regrant", 32'(bus.HOST_GNT), 32'd1);
    chk("regrant_addr", 32'(bus.MEM_ADDR), 32'd5);
    chk("regrant_we", 32'(bus.MEM_WE), 32'd0);
    drive(8'h00, 1'b0, 4'h0, 1'b0);
    bus.HOST_REQ = 1'b0;

    // Abort after two payload writes; the next frame restarts at base 8.
    drive(8'hAA, 1'b0, 4'h0, 1'b0);
    drive(8'h55, 1'b0, 4'h0, 1'b0);
    drive(8'h01, 1'b1, 4'h8, 1'b0);
    drive(8'h02, 1'b1, 4'h9, 1'b0);
    @(negedge CLK);
    bus.ENABLE = 1'b0; bus.DBUS = 8'h03;
    settle();
    chk("abort_we", 32'(bus.MEM_WE), 32'd0);
    chk("abort_rdy", 32'(bus.FRAME_RDY), 32'd0);
    drive(8'h04, 1'b0, 4'h0, 1'b0);
    drive(8'h00, 1'b0, 4'h0, 1'b0);
    bus.ENABLE = 1'b1;
    drive(8'h00, 1'b0, 4'h0, 1'b0);
    do_frame(4'h8, 8'h90, 1'b1, 1'b1);

`ifdef FCC_REARM_EN
    // Second unread frame raises the sticky OVERRUN on its last write.
    do_frame(4'hC, 8'hC8, 1'b1, 1'b0);
    chk("ovr_first", 32'(bus.OVERRUN), 32'd0);
    drive(8'hAA, 1'b0, 4'h0, 1'b0);
    drive(8'h55, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) drive(8'hD0 + 8'(i), 1'b1, 4'(i), 1'b0);
    settle();
    chk("ovr_before_last", 32'(bus.OVERRUN), 32'd0);
    drive(8'hD3, 1'b1, 4'h3, 1'b0);
    settle();
    chk("ovr_on_last", 32'(bus.OVERRUN), 32'd1);
    chk("ovr_base", 32'(bus.FRAME_BASE), 32'd0);
    drive(8'h00, 1'b0, 4'h0, 1'b1);
    drive(8'h00, 1'b0, 4'h0, 1'b0);
    chk("ovr_ack_rdy", 32'(bus.FRAME_RDY), 32'd0);
    chk("ovr_sticky", 32'(bus.OVERRUN), 32'd1);
`else
    // DONE blocks hunting until the host acknowledges.
    do_frame(4'hC, 8'hC8, 1'b1, 1'b0);
    drive(8'hAA, 1'b0, 4'h0, 1'b0);
    drive(8'h55, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) drive(8'h70 + 8'(i), 1'b0, 4'h0, 1'b0);
    settle();
    chk("done_holds_rdy", 32'(bus.FRAME_RDY), 32'd1);
    chk("done_base", 32'(bus.FRAME_BASE), 32'd12);
    drive(8'h00, 1'b0, 4'h0, 1'b1);
    drive(8'h00, 1'b0, 4'h0, 1'b0);
    chk("done_ack_rdy", 32'(bus.FRAME_RDY), 32'd0);
    do_frame(4'h0, 8'hD0, 1'b1, 1'b1);
`endif

    // Asynchronous reset mid-capture, then the pointer restarts at 0.
    drive(8'hAA, 1'b0, 4'h0, 1'b0);
    drive(8'h55, 1'b0, 4'h0, 1'b0);
    drive(8'h5A, 1'b1, 4'h4, 1'b0);
    drive(8'h5B, 1'b1, 4'h5, 1'b0);
    @(negedge CLK);
    bus.DBUS = 8'h00;
    #2 RST = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge CLK);
    RST = 1'b0;
    drive(8'h00, 1'b0, 4'h0, 1'b0);
    do_frame(4'h0, 8'hE0, 1'b1, 1'b1);

    repeat (3) @(negedge CLK);
    chk("exp_writes_left", 32'(exp_q.size()), 32'd0);
    chk("exp_frames_left", 32'(frame_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
